// File: rtl/router_ingress.sv
// router_ingress: parses header/payload/parity bytes and steers them into one of three write-side FIFOs
module router_ingress (
    input  logic       wr_clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] fifo_full,
    output logic [2:0] fifo_wr_en,
    output logic [7:0] fifo_data,
    output logic       busy,
    output logic       pkt_done,
    output logic       parity_err,
    output logic [7:0] err_cnt,
    output logic [7:0] drop_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, DROP} state_t;
    state_t state, state_n;
    logic [7:0] hdr_reg, par_acc;
    logic [5:0] len_cnt;
    logic [6:0] drop_rem;
    logic [1:0] dest;
    logic [3:0] full_ext, dest_hot;
    logic       dest_full, accept, wr, pass;
    // Address 3 never reaches a FIFO; padding its full bit high keeps the index in range and harmless.
    assign dest      = hdr_reg[1:0];
    assign full_ext  = {1'b1, fifo_full};
    assign dest_full = full_ext[dest];
    assign dest_hot  = 4'b0001 << dest;
    assign pass      = state == PAYLOAD || state == PARITY;
    assign in_ready  = reset && (state == IDLE || state == DROP || (pass && !dest_full));
    assign accept    = in_valid && in_ready;
    assign wr        = state == HDR ? !dest_full : pass && accept;
    assign fifo_wr_en = wr ? dest_hot[2:0] : 3'b000;
    assign fifo_data = state == HDR ? hdr_reg : in_data;
    assign busy      = state != IDLE;
    // State register
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    // Next-state decode driven by accepted bytes and the header write
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = in_data[1:0] == 2'd3 ? DROP : HDR;
            HDR:     if (wr) state_n = len_cnt != 6'd0 ? PAYLOAD : PARITY;
            PAYLOAD: if (accept && len_cnt == 6'd1) state_n = PARITY;
            PARITY:  if (accept) state_n = IDLE;
            DROP:    if (accept && drop_rem == 7'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Header capture, parity accumulation, byte counters and saturating statistics
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            hdr_reg    <= 8'd0;
            par_acc    <= 8'd0;
            len_cnt    <= 6'd0;
            drop_rem   <= 7'd0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            err_cnt    <= 8'd0;
            drop_cnt   <= 8'd0;
        end else begin
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        hdr_reg <= in_data;
                        par_acc <= in_data;
                        len_cnt <= in_data[7:2];
                        if (in_data[1:0] == 2'd3) drop_rem <= {1'b0, in_data[7:2]} + 7'd1;
                    end
                    PAYLOAD: begin
                        par_acc <= par_acc ^ in_data;
                        len_cnt <= len_cnt - 6'd1;
                    end
                    PARITY: begin
                        pkt_done   <= 1'b1;
                        parity_err <= par_acc != in_data;
                        if (par_acc != in_data && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                    DROP: begin
                        drop_rem <= drop_rem - 7'd1;
                        if (drop_rem == 7'd1 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_router_ingress.sv
// tb_router_ingress: directed packets against router_ingress with hand-computed expectations
module tb_router_ingress;
    logic       wr_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] fifo_full = 3'd0;
    logic [2:0] fifo_wr_en;
    logic [7:0] fifo_data;
    logic       busy, pkt_done, parity_err;
    logic [7:0] err_cnt, drop_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_wait = 0;
    int done_cnt = 0;
    int t0 = 0;
    logic [10:0] wq[$];

    router_ingress dut (
        .wr_clk(wr_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .busy(busy), .pkt_done(pkt_done),
        .parity_err(parity_err), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: log every FIFO write and count completion pulses
    always @(negedge wr_clk) begin
        if (fifo_wr_en != 3'd0) begin
            wq.push_back({fifo_wr_en, fifo_data});
            check("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
        end
        if (pkt_done) done_cnt++;
    end

    task automatic sync;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        in_data = b;
        in_valid = 1'b1;
        @(negedge wr_clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge wr_clk);
        end
        if (w >= 100) check("send_timeout", 32'd1, 32'd0);
        @(posedge wr_clk);
        #1;
        last_wait = w;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic expect_writes(input string tag, input logic [2:0] en, input logic [39:0] v, input int n);
        check({tag, "_count"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check(tag, (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'({en, v[39-8*i -: 8]}));
        wq.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] drop_pkt;
        drop_pkt = 32'h0B01_0209;
        #2 reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h0C;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        in_valid = 1'b0;
        repeat (2) sync;
        reset = 1'b1;
        wq.delete();
        done_cnt = 0;

        send(8'h0C);
        t0 = last_acc;
        check("good_hdr_wait", 32'(last_wait), 32'd0);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h0C);
        check("good_cycles", 32'(last_acc - t0), 32'd5);
        @(negedge wr_clk);
        check("good_pkt_done", 32'(pkt_done), 32'd1);
        check("good_parity_err", 32'(parity_err), 32'd0);
        check("good_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge wr_clk);
        check("good_done_width", 32'(pkt_done), 32'd0);
        check("good_done_count", 32'(done_cnt), 32'd1);
        expect_writes("good_wr", 3'b001, {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C}, 5);

        sync;
        send(8'h05);
        send(8'hAA);
        send(8'h00);
        @(negedge wr_clk);
        check("bad_pkt_done", 32'(pkt_done), 32'd1);
        check("bad_parity_err", 32'(parity_err), 32'd1);
        check("bad_err_cnt", 32'(err_cnt), 32'd1);
        expect_writes("bad_wr", 3'b010, {8'h05, 8'hAA, 8'h00, 16'h0}, 3);

        sync;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send(drop_pkt[31-8*i -: 8]);
            check("drop_ready", 32'(last_wait), 32'd0);
        end
        @(negedge wr_clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        sync;
        @(negedge wr_clk);
        check("drop_no_done", 32'(done_cnt), 32'd0);
        expect_writes("drop_wr", 3'b000, 40'd0, 0);

        sync;
        fifo_full = 3'b100;
        send(8'h02);
        repeat (5) begin
            @(negedge wr_clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_wr_en", 32'(fifo_wr_en), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        sync;
        fifo_full = 3'b000;
        @(negedge wr_clk);
        check("bp_hdr_wr_en", 32'(fifo_wr_en), 32'b100);
        check("bp_hdr_data", 32'(fifo_data), 32'h02);
        sync;
        send(8'h02);
        check("bp_parity_wait", 32'(last_wait), 32'd0);
        @(negedge wr_clk);
        check("bp_pkt_done", 32'(pkt_done), 32'd1);
        check("bp_parity_err", 32'(parity_err), 32'd0);
        expect_writes("bp_wr", 3'b100, {8'h02, 8'h02, 24'h0}, 2);

        sync;
        send(8'h0C);
        send(8'hA1);
        repeat (3) begin
            @(negedge wr_clk);
            check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        sync;
        send(8'hA2);
        check("stall_resume_wait", 32'(last_wait), 32'd0);
        expect_writes("stall_wr", 3'b001, {8'h0C, 8'hA1, 8'hA2, 16'h0}, 3);
        in_data = 8'hA3;
        in_valid = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        sync;
        in_valid = 1'b0;
        reset = 1'b1;
        wq.delete();
        send(8'h04);
        send(8'h55);
        send(8'h51);
        @(negedge wr_clk);
        check("post_rst_done", 32'(pkt_done), 32'd1);
        check("post_rst_parity_err", 32'(parity_err), 32'd0);
        expect_writes("post_rst_wr", 3'b001, {8'h04, 8'h55, 8'h51, 16'h0}, 3);

        sync;
        for (int i = 1; i <= 257; i++) begin
            send(8'h00);
            send(8'hFF);
            if (i >= 254) check($sformatf("sat_err_cnt_%0d", i), 32'(err_cnt), (i >= 255) ? 32'd255 : 32'd254);
        end
        wq.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_ingress.md
# router_ingress

Write-clock-domain packet parser at the input of the 1x3 router, directly upstream of the three asynchronous 32-byte FIFOs. It accepts a byte stream over a valid/ready handshake, decodes the destination from the header, and writes header, payload and parity into the selected FIFO while honouring that FIFO's full flag. It also checks packet parity, drops packets with an invalid address, and keeps saturating error and drop counters.

## Interface
- No parameters. The data width is fixed at 8 bits and the destination count is fixed at 3.
- wr_clk  in  1  write clock; the three FIFO write sides run on this clock.
- reset  in  1  reset, asynchronous, active-low.
- in_data  in  8  input byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle; combinational.
- fifo_full  in  3  wr_full of FIFO 0..2.
- fifo_wr_en  out  3  one-hot write enable to FIFO 0..2; combinational.
- fifo_data  out  8  write data to all FIFOs; combinational.
- busy  out  1  high whenever state != IDLE.
- pkt_done  out  1  registered one-cycle pulse after the parity byte of a written packet is accepted.
- parity_err  out  1  registered one-cycle pulse, coincident with pkt_done, when parity mismatches.
- err_cnt  out  8  parity-error count; saturates at 255.
- drop_cnt  out  8  dropped-packet count; saturates at 255.

## Operation
- Packet format:
  - header = {len[5:0], addr[1:0]}, with len 0..63;
  - followed by len payload bytes;
  - followed by 1 parity byte, equal to the XOR of the header and all payload bytes.
- A byte is accepted when in_valid && in_ready.
- States: IDLE, HDR, PAYLOAD, PARITY, DROP.
- IDLE:
  - in_ready=1 and no writes.
  - On accept: hdr_reg<=in_data, par_acc<=in_data, len_cnt<=in_data[7:2].
  - If addr==3: go to DROP with drop_rem<=len+1.
  - Otherwise: go to HDR.
- HDR:
  - in_ready=0, fifo_data=hdr_reg, fifo_wr_en[dest]=!fifo_full[dest], where dest=hdr_reg[1:0].
  - On write: go to PAYLOAD if len_cnt!=0, otherwise go to PARITY.
- PAYLOAD:
  - in_ready=!fifo_full[dest], fifo_data=in_data, fifo_wr_en[dest]=accept.
  - Per accepted byte: par_acc^=in_data and len_cnt-=1.
  - The accept with len_cnt==1 moves to PARITY.
- PARITY:
  - Same pass-through write as PAYLOAD.
  - On accept: pkt_done<=1; parity_err<=(par_acc!=in_data); err_cnt increments if mismatch and err_cnt<255; go to IDLE.
  - The parity byte is always written to the FIFO, whether or not it matches.
- DROP:
  - in_ready=1 and no writes.
  - Each accept decrements drop_rem; the accept with drop_rem==1 goes to IDLE and increments drop_cnt (saturating).
- fifo_wr_en bits other than dest are always 0. fifo_wr_en is never asserted while fifo_full of that destination is high.
- Reset values: state IDLE; all counters and registers 0; pkt_done, parity_err, fifo_wr_en and busy all 0. in_ready is forced 0 while reset is low.
- Reset asserted mid-packet clears all state immediately. The FIFOs share this reset, so any partial packet is discarded. The first byte after reset release is treated as a header.

## Timing
- Header accept at cycle N; earliest header write at N+1 (HDR).
- First payload byte can be accepted at N+2.
- A packet with L payload bytes needs at least L+3 cycles; the next header can be accepted the cycle after the parity accept.
- pkt_done and parity_err are high for exactly the one cycle after the parity accept.
- A dropped packet takes exactly len+2 accepts (header, len payload bytes, parity) and produces no pkt_done.
- If fifo_full[dest] asserts mid-packet, in_ready falls in that same cycle; transfer resumes in the cycle full deasserts, with no byte lost or duplicated.
- in_valid low stalls any state except HDR, which does not depend on in_valid.

## Test plan
- Good packet:
  - Stimulus: after reset, send 0x0C, 0x11, 0x22, 0x33, 0x0C back-to-back.
  - Required response: fifo_wr_en=3'b001 for 5 writes with data 0C, 11, 22, 33, 0C; one pkt_done pulse; parity_err=0; err_cnt=0; packet completes in 6 cycles.
- Bad parity:
  - Stimulus: send 0x05, 0xAA, 0x00.
  - Required response: 3 writes to FIFO 1; parity_err and pkt_done pulse together; err_cnt=1.
- Drop:
  - Stimulus: send 0x0B, 0x01, 0x02, 0x09.
  - Required response: in_ready=1 for all 4 bytes; fifo_wr_en stays 0; drop_cnt=1; no pkt_done; busy returns to 0.
- Backpressure, len=0:
  - Stimulus: hold fifo_full=3'b100 and send 0x02. Keep full high for 5 cycles, then release it, then send parity 0x02.
  - Required response: no write and in_ready=0 while full is high; header written the cycle full falls; parity written next; parity_err=0.
- Mid-payload stall and reset:
  - Stimulus: mid-payload, drop in_valid for 3 cycles. Then assert reset mid-payload.
  - Required response: during the stall, no writes and the state is held. On reset, fifo_wr_en and busy are 0 immediately. After release, 0x04, 0x55, 0x51 goes to FIFO 0 cleanly.
- Saturation:
  - Stimulus: send 256 bad-parity packets, then one more.
  - Required response: err_cnt holds at 255.
